// File: rtl/rv32i_core.sv
// Single-cycle RV32I core with private instruction memory, data memory and
// register file. Every instruction completes fetch-to-writeback in one clock.
module rv32i_core #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  logic [31:0] instr_mem [IMEM_WORDS];
  logic [31:0] data_mem  [DMEM_WORDS];
  logic [31:0] regfile   [32];

  opcode_e     opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] pc_plus4, next_pc;
  logic [31:0] alu_b, alu_out;
  logic [4:0]  shamt;
  logic        br_taken;
  logic [31:0] mem_addr, ld_word, ld_shift, load_val;
  logic [1:0]  byte_off;
  logic [DAW-1:0] dmem_idx;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        rd_we, mem_we;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign instr    = instr_mem[pc[IAW+1:2]];
  assign opcode   = opcode_e'(instr[6:0]);
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];

  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u    = {instr[31:12], 12'h000};
  assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign rs1_val  = (rs1 == 5'd0) ? '0 : regfile[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : regfile[rs2];
  assign pc_plus4 = pc + 32'd4;

  assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign byte_off = mem_addr[1:0];
  assign dmem_idx = mem_addr[DAW+1:2];
  assign ld_word  = data_mem[dmem_idx];
  assign ld_shift = ld_word >> {byte_off, 3'b000};

  assign unused_bits = ^{pc[1:0], pc[31:IAW+2], mem_addr[31:DAW+2], ld_shift[31:16]};

  // ALU shared by OP and OP-IMM; SRA/SRAI both key off instr[30]
  always_comb begin
    alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    shamt   = alu_b[4:0];
    alu_out = '0;
    case (funct3)
      3'b000: alu_out = (opcode == OPC_OP && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
      3'b001: alu_out = rs1_val << shamt;
      3'b010: alu_out = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011: alu_out = {31'b0, rs1_val < alu_b};
      3'b100: alu_out = rs1_val ^ alu_b;
      3'b101: alu_out = instr[30] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      3'b110: alu_out = rs1_val | alu_b;
      3'b111: alu_out = rs1_val & alu_b;
      default: alu_out = '0;
    endcase
  end

  // Branch condition
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000: br_taken = (rs1_val == rs2_val);
      3'b001: br_taken = (rs1_val != rs2_val);
      3'b100: br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110: br_taken = (rs1_val <  rs2_val);
      3'b111: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Load lane extraction from the addressed word
  always_comb begin
    load_val = ld_word;
    case (funct3)
      3'b000: load_val = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001: load_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100: load_val = {24'b0, ld_shift[7:0]};
      3'b101: load_val = {16'b0, ld_shift[15:0]};
      default: load_val = ld_word;
    endcase
  end

  // Store byte enables; lanes shifted past byte 3 are dropped
  always_comb begin
    st_wdata = rs2_val << {byte_off, 3'b000};
    case (funct3[1:0])
      2'b00:   st_be = 4'b0001 << byte_off;
      2'b01:   st_be = 4'b0011 << byte_off;
      default: st_be = 4'b1111 << byte_off;
    endcase
  end

  // Main decode: writeback selection, store enable, next PC
  always_comb begin
    next_pc = pc_plus4;
    rd_we   = 1'b0;
    rd_data = '0;
    mem_we  = 1'b0;
    case (opcode)
      OPC_LUI:    begin rd_we = 1'b1; rd_data = imm_u; end
      OPC_AUIPC:  begin rd_we = 1'b1; rd_data = pc + imm_u; end
      OPC_JAL:    begin rd_we = 1'b1; rd_data = pc_plus4; next_pc = pc + imm_j; end
      OPC_JALR:   begin rd_we = 1'b1; rd_data = pc_plus4; next_pc = (rs1_val + imm_i) & ~32'd1; end
      OPC_BRANCH: if (br_taken) next_pc = pc + imm_b;
      OPC_LOAD:   begin rd_we = 1'b1; rd_data = load_val; end
      OPC_STORE:  mem_we = 1'b1;
      OPC_OPIMM,
      OPC_OP:     begin rd_we = 1'b1; rd_data = alu_out; end
      default:    ;
    endcase
  end

  // Program counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= next_pc;
  end

  // Register file; x0 is never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (rd_we && rd != 5'd0) begin
      regfile[rd] <= rd_data;
    end
  end

  // Data memory: not cleared by reset, but a store in flight during reset is suppressed
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      for (int unsigned i = 0; i < 4; i++)
        if (st_be[i]) data_mem[dmem_idx][8*i +: 8] <= st_wdata[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_rv32i_core.sv
// Testbench for rv32i_core: directed ISA scenarios plus random programs,
// run in lockstep with an instruction-level reference model.
module tb_rv32i_core;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc, instr;

  rv32i_core #(.IMEM_WORDS(256), .DMEM_WORDS(256), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_imem [256];
  logic [31:0] m_dmem [256];
  logic [31:0] m_rf   [32];
  logic [31:0] m_pc;

  function automatic logic [31:0] m_rd(input logic [4:0] r);
    return (r == 5'd0) ? 32'h0 : m_rf[r];
  endfunction

  task automatic m_wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_rf[r] = v;
  endtask

  task automatic m_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
  endtask

  task automatic m_step();
    logic [31:0] ins, a, b, iimm, simm, bimm, jimm, uimm, addr, word, res, nxt;
    logic [7:0]  by;
    logic [15:0] hw;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    int          off, n;
    bit          taken;
    ins  = m_imem[m_pc[9:2]];
    rd   = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15]; rs2 = ins[24:20];
    a    = m_rd(rs1);
    b    = m_rd(rs2);
    iimm = 32'($signed(ins) >>> 20);
    simm = {iimm[31:5], ins[11:7]};
    bimm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    jimm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    uimm = {ins[31:12], 12'h000};
    nxt  = m_pc + 32'd4;
    res  = 32'h0;
    taken = 1'b0;
    case (ins[6:0])
      7'h37: m_wr(rd, uimm);
      7'h17: m_wr(rd, m_pc + uimm);
      7'h6f: begin m_wr(rd, m_pc + 32'd4); nxt = m_pc + jimm; end
      7'h67: begin nxt = (a + iimm) & ~32'h1; m_wr(rd, m_pc + 32'd4); end
      7'h63: begin
        case (f3)
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = ($signed(a) <  $signed(b));
          3'd5: taken = ($signed(a) >= $signed(b));
          3'd6: taken = (a <  b);
          3'd7: taken = (a >= b);
          default: taken = 1'b0;
        endcase
        if (taken) nxt = m_pc + bimm;
      end
      7'h03: begin
        addr = a + iimm;
        word = m_dmem[addr[9:2]];
        off  = int'(addr[1:0]);
        by   = 8'(word >> (8*off));
        hw   = 16'(word >> (8*off));
        case (f3)
          3'd0: res = {{24{by[7]}}, by};
          3'd1: res = {{16{hw[15]}}, hw};
          3'd4: res = {24'h0, by};
          3'd5: res = {16'h0, hw};
          default: res = word;
        endcase
        m_wr(rd, res);
      end
      7'h23: begin
        addr = a + simm;
        off  = int'(addr[1:0]);
        n    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        for (int k = 0; k < n; k++)
          if (off + k < 4) m_dmem[addr[9:2]][8*(off+k) +: 8] = b[8*k +: 8];
      end
      7'h13, 7'h33: begin
        if (ins[6:0] == 7'h13) b = iimm;
        case (f3)
          3'd0: res = (ins[5] && ins[30]) ? a - b : a + b;
          3'd1: res = a << b[4:0];
          3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: res = (a < b) ? 32'd1 : 32'd0;
          3'd4: res = a ^ b;
          3'd5: res = ins[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'd6: res = a | b;
          default: res = a & b;
        endcase
        m_wr(rd, res);
      end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
      input logic [2:0] f3, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
      input logic [19:0] imm);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  f7;
    int          k, j, ofs;
    rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    imm = 12'($urandom);
    ofs = $urandom_range(0, 64) - 32;
    k   = $urandom_range(0, 11);
    case (k)
      0: return enc_u(7'h37, rd, 20'($urandom));
      1: return enc_u(7'h17, rd, 20'($urandom));
      3, 4: begin
        f3 = 3'($urandom);
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return enc_r(f7, rs2, rs1, f3, rd);
      end
      5: begin
        j  = $urandom_range(0, 4);
        f3 = (j < 3) ? 3'(j) : 3'(j + 1);
        return enc_i(7'h03, rd, f3, rs1, imm);
      end
      6: return enc_s(3'($urandom_range(0, 2)), rs1, rs2, imm);
      7: begin
        j  = $urandom_range(0, 5);
        f3 = (j < 2) ? 3'(j) : 3'(j + 2);
        return enc_b(f3, rs1, rs2, 13'(ofs * 2));
      end
      8: return enc_j(rd, 21'(ofs * 4));
      9: return enc_i(7'h67, rd, 3'd0, rs1, 12'($urandom_range(0, 64)));
      10: begin
        j = $urandom_range(0, 3);
        if (j == 0) return 32'h0000000f;
        if (j == 1) return 32'h00000073;
        if (j == 2) return 32'h00100073;
        return {25'($urandom), 7'h7f};
      end
      default: begin
        f3 = 3'($urandom);
        if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
        else if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, imm[4:0]};
        return enc_i(7'h13, rd, f3, rs1, imm);
      end
    endcase
  endfunction

  // ---------------- sequencing helpers ----------------
  logic [31:0] prog [$];
  logic [31:0] x1_prev;
  int          x1_sets;

  task automatic set_imem(input int idx, input logic [31:0] w);
    dut.instr_mem[idx] = w;
    m_imem[idx]        = w;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) set_imem(i, (i < prog.size()) ? prog[i] : 32'h0);
  endtask

  // Asserts reset between clock edges, checks the asynchronous effect, releases at the next negedge
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_pc"}, pc, 32'h0);
    for (int i = 0; i < 32; i++) check($sformatf("%s_x%0d", tag, i), dut.regfile[i], 32'h0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step_cycle();
    check("pc", pc, m_pc);
    check("instr", instr, m_imem[m_pc[9:2]]);
    m_step();
    @(negedge clk);
    if (dut.regfile[1] != x1_prev && dut.regfile[1] == 32'd102) x1_sets++;
    x1_prev = dut.regfile[1];
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++) check($sformatf("%s_x%0d", tag, i), dut.regfile[i], m_rd(5'(i)));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_dmem[i] = 32'h0;
    x1_prev = 32'h0;
    x1_sets = 0;

    // Clear data memory through the core itself: sw x0, 4*i(x0) for every word
    prog.delete();
    for (int i = 0; i < 256; i++) prog.push_back(enc_s(3'd2, 5'd0, 5'd0, 12'(4 * i)));
    load_prog();
    #1;
    do_reset("reset0");
    run(256);

    // Spec program: loop at 16..28, x1 set once, x15 = 1 each pass
    prog = '{32'h06600093, 32'h40b28233, 32'h00042303, 32'h00902423,
             32'h00a60693, 32'h00f707b3, 32'h00188793, 32'hfff10ae3};
    load_prog();
    do_reset("reset1");
    x1_prev = 32'h0;
    x1_sets = 0;
    run(4);
    for (int pass = 0; pass < 4; pass++) begin
      for (int k = 0; k < 4; k++) begin
        check("loop_pc", pc, 32'(16 + 4 * k));
        step_cycle();
      end
      check("x15_pass", dut.regfile[15], 32'd1);
    end
    check("x1_set_once", 32'(x1_sets), 32'd1);
    check("x1_val", dut.regfile[1], 32'd102);
    check_regs("loop");
    do_reset("midloop");

    // Store / load and byte lanes
    prog = '{enc_i(7'h13, 5'd9, 3'd0, 5'd0, 12'hffb),
             enc_s(3'd2, 5'd0, 5'd9, 12'd8),
             enc_i(7'h03, 5'd7, 3'd2, 5'd0, 12'd8),
             enc_i(7'h03, 5'd3, 3'd0, 5'd0, 12'd8),
             enc_i(7'h03, 5'd10, 3'd4, 5'd0, 12'd8),
             enc_s(3'd0, 5'd0, 5'd9, 12'd13),
             enc_i(7'h03, 5'd12, 3'd2, 5'd0, 12'd12),
             enc_i(7'h03, 5'd13, 3'd0, 5'd0, 12'd13),
             enc_i(7'h03, 5'd14, 3'd5, 5'd0, 12'd12),
             enc_i(7'h03, 5'd16, 3'd1, 5'd0, 12'd12)};
    load_prog();
    do_reset("reset2");
    run(10);
    check("lw_x7", dut.regfile[7], 32'hFFFFFFFB);
    check("dmem2", dut.data_mem[2], 32'hFFFFFFFB);
    check("lb_x3", dut.regfile[3], 32'hFFFFFFFB);
    check("lbu_x10", dut.regfile[10], 32'h000000FB);
    check("sb_lw_x12", dut.regfile[12], 32'h0000FB00);
    check("lb_off1_x13", dut.regfile[13], 32'hFFFFFFFB);
    check("lhu_x14", dut.regfile[14], 32'h0000FB00);
    check("lh_x16", dut.regfile[16], 32'hFFFFFB00);

    // Jumps
    prog.delete();
    for (int i = 0; i < 8; i++) prog.push_back(enc_i(7'h13, 5'd0, 3'd0, 5'd0, 12'd0));
    prog.push_back(enc_j(5'd5, 21'd8));
    prog.push_back(enc_i(7'h13, 5'd6, 3'd0, 5'd0, 12'd1));
    prog.push_back(enc_i(7'h13, 5'd1, 3'd0, 5'd0, 12'd102));
    prog.push_back(enc_i(7'h67, 5'd0, 3'd0, 5'd1, 12'd0));
    load_prog();
    set_imem(25, enc_i(7'h13, 5'd20, 3'd0, 5'd0, 12'd7));
    do_reset("reset3");
    run(8);
    check("jal_at_pc", pc, 32'd32);
    run(1);
    check("jal_next_pc", pc, 32'd40);
    check("jal_x5", dut.regfile[5], 32'd36);
    run(2);
    check("jalr_pc", pc, 32'd102);
    run(1);
    check("jalr_tgt_x20", dut.regfile[20], 32'd7);
    check("jal_skip_x6", dut.regfile[6], 32'd0);
    check("post_jalr_pc", pc, 32'd106);

    // Arithmetic edges and x0 protection
    prog = '{enc_u(7'h37, 5'd1, 20'h80000),
             enc_i(7'h13, 5'd1, 3'd0, 5'd1, 12'hfff),
             enc_i(7'h13, 5'd2, 3'd0, 5'd1, 12'd1),
             enc_i(7'h13, 5'd3, 3'd0, 5'd0, 12'hfff),
             enc_i(7'h13, 5'd4, 3'd0, 5'd0, 12'd1),
             enc_r(7'h00, 5'd4, 5'd3, 3'd2, 5'd5),
             enc_r(7'h00, 5'd4, 5'd3, 3'd3, 5'd6),
             enc_u(7'h37, 5'd7, 20'h80000),
             enc_i(7'h13, 5'd8, 3'd0, 5'd0, 12'd31),
             enc_r(7'h20, 5'd8, 5'd7, 3'd5, 5'd9),
             enc_i(7'h13, 5'd10, 3'd5, 5'd7, 12'h41f),
             enc_i(7'h13, 5'd0, 3'd0, 5'd0, 12'd5),
             enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd11),
             enc_r(7'h20, 5'd3, 5'd4, 3'd0, 5'd12)};
    load_prog();
    do_reset("reset4");
    run(14);
    check("max_x1", dut.regfile[1], 32'h7FFFFFFF);
    check("wrap_add_x2", dut.regfile[2], 32'h80000000);
    check("slt_x5", dut.regfile[5], 32'd1);
    check("sltu_x6", dut.regfile[6], 32'd0);
    check("sra_x9", dut.regfile[9], 32'hFFFFFFFF);
    check("srai_x10", dut.regfile[10], 32'hFFFFFFFF);
    check("x0_keep", dut.regfile[0], 32'd0);
    check("x0_read_x11", dut.regfile[11], 32'd0);
    check("sub_x12", dut.regfile[12], 32'd2);

    // Reset with a store in flight: the store must not land
    prog = '{enc_i(7'h13, 5'd9, 3'd0, 5'd0, 12'hffb),
             enc_s(3'd2, 5'd0, 5'd9, 12'd16)};
    load_prog();
    do_reset("reset5");
    run(1);
    reset = 1'b0;
    #1;
    check("inflight_pc", pc, 32'h0);
    check("inflight_x9", dut.regfile[9], 32'h0);
    @(posedge clk);
    #1;
    check("inflight_dmem4", dut.data_mem[4], m_dmem[4]);
    check("inflight_pc_held", pc, 32'h0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    run(2);
    check("restart_dmem4", dut.data_mem[4], 32'hFFFFFFFB);

    // Random programs against the model
    for (int p = 0; p < 5; p++) begin
      prog.delete();
      for (int i = 0; i < 64; i++) prog.push_back(rand_instr());
      load_prog();
      do_reset($sformatf("rreset%0d", p));
      run(200);
      check_regs($sformatf("rand%0d", p));
      for (int i = 0; i < 256; i++)
        check($sformatf("rand%0d_dmem%0d", p, i), dut.data_mem[i], m_dmem[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
